// File: rtl/mac_fixed_complex.sv
// rtl/mac_fixed_complex.sv - pipelined complex fixed-point multiply-accumulate over framed sample streams
// Three register stages (products, complex sums, accumulate/close) frozen together by output backpressure.
module mac_fixed_complex #(
  parameter int QI       = 4,
  parameter int QF       = 4,
  parameter int MAX_LEN  = 16,
  parameter int SATURATE = 1,
  localparam int WIDTH   = QI + QF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             in_conj,
  input  logic [WIDTH-1:0] a_Re,
  input  logic [WIDTH-1:0] a_Im,
  input  logic [WIDTH-1:0] b_Re,
  input  logic [WIDTH-1:0] b_Im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_Re,
  output logic [WIDTH-1:0] y_Im,
  output logic             overflow,
  output logic             forced
);
  localparam int PW    = 2 * WIDTH;
  localparam int SW    = PW + 1;
  localparam int CW    = $clog2(MAX_LEN);
  localparam int ACC_W = SW + CW;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic                    w_en;
  logic signed [PW-1:0]    w_ar, w_ai, w_br, w_bi;
  logic signed [PW-1:0]    r_p_rr, r_p_ii, r_p_ir, r_p_ri;
  logic                    r_s1_valid, r_s1_last, r_s1_conj;
  logic signed [SW-1:0]    w_rr, w_ii, w_ir, w_ri;
  logic signed [SW-1:0]    r_s2_re, r_s2_im;
  logic                    r_s2_valid, r_s2_last;
  logic signed [ACC_W-1:0] r_acc_re, r_acc_im;
  logic signed [ACC_W-1:0] w_sum_re, w_sum_im, w_tot_re, w_tot_im;
  logic [CW-1:0]           r_cnt;
  logic                    r_first;
  logic                    w_beat, w_close;
  logic [WIDTH:0]          w_red_re, w_red_im;

  // A pending, unaccepted result stalls every stage including the input.
  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;

  assign w_ar = {{WIDTH{a_Re[WIDTH-1]}}, a_Re};
  assign w_ai = {{WIDTH{a_Im[WIDTH-1]}}, a_Im};
  assign w_br = {{WIDTH{b_Re[WIDTH-1]}}, b_Re};
  assign w_bi = {{WIDTH{b_Im[WIDTH-1]}}, b_Im};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_conj  <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_last  <= in_last;
      r_s1_conj  <= in_conj;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_p_rr <= w_ar * w_br;
      r_p_ii <= w_ai * w_bi;
      r_p_ir <= w_ai * w_br;
      r_p_ri <= w_ar * w_bi;
    end
  end

  assign w_rr = {r_p_rr[PW-1], r_p_rr};
  assign w_ii = {r_p_ii[PW-1], r_p_ii};
  assign w_ir = {r_p_ir[PW-1], r_p_ir};
  assign w_ri = {r_p_ri[PW-1], r_p_ri};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      if (r_s1_conj) begin
        r_s2_re <= w_rr + w_ii;
        r_s2_im <= w_ir - w_ri;
      end else begin
        r_s2_re <= w_rr - w_ii;
        r_s2_im <= w_ir + w_ri;
      end
    end
  end

  assign w_sum_re = {{CW{r_s2_re[SW-1]}}, r_s2_re};
  assign w_sum_im = {{CW{r_s2_im[SW-1]}}, r_s2_im};
  assign w_tot_re = (r_first ? '0 : r_acc_re) + w_sum_re;
  assign w_tot_im = (r_first ? '0 : r_acc_im) + w_sum_im;
  assign w_beat   = r_s2_valid && w_en;
  assign w_close  = w_beat && (r_s2_last || (r_cnt == CW'(MAX_LEN - 1)));

  // Floor-shift to Q(QI).(QF), then clamp or wrap; bit WIDTH carries the overflow flag.
  function automatic logic [WIDTH:0] f_reduce(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    logic [WIDTH:0]          r;
    s = v >>> QF;
    r = {1'b0, s[WIDTH-1:0]};
    if (s > Y_MAX) begin
      r[WIDTH] = 1'b1;
      if (SATURATE != 0) r[WIDTH-1:0] = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (s < Y_MIN) begin
      r[WIDTH] = 1'b1;
      if (SATURATE != 0) r[WIDTH-1:0] = {1'b1, {(WIDTH-1){1'b0}}};
    end
    return r;
  endfunction

  assign w_red_re = f_reduce(w_tot_re);
  assign w_red_im = f_reduce(w_tot_im);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y_Re      <= '0;
      y_Im      <= '0;
      overflow  <= 1'b0;
      forced    <= 1'b0;
      r_acc_re  <= '0;
      r_acc_im  <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b1;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (w_close) begin
        y_Re      <= w_red_re[WIDTH-1:0];
        y_Im      <= w_red_im[WIDTH-1:0];
        overflow  <= w_red_re[WIDTH] | w_red_im[WIDTH];
        forced    <= !r_s2_last;
        out_valid <= 1'b1;
        r_acc_re  <= '0;
        r_acc_im  <= '0;
        r_cnt     <= '0;
        r_first   <= 1'b1;
      end else if (w_beat) begin
        r_acc_re  <= w_tot_re;
        r_acc_im  <= w_tot_im;
        r_cnt     <= r_cnt + 1'b1;
        r_first   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_fixed_complex.sv
// tb/tb_mac_fixed_complex.sv - self-checking bench for mac_fixed_complex
// Saturating and wrapping instances share stimulus; a frame-level arithmetic model predicts every result.
module tb_mac_fixed_complex;
  localparam int QI = 4;
  localparam int QF = 4;
  localparam int W = QI + QF;
  localparam int MAX_LEN = 16;

  logic clk;
  logic rst, in_valid, in_last, in_conj, out_ready;
  logic [W-1:0] a_re, a_im, b_re, b_im;
  logic in_ready, out_valid, overflow, forced;
  logic [W-1:0] y_re, y_im;
  logic in_ready_w, out_valid_w, overflow_w, forced_w;
  logic [W-1:0] y_re_w, y_im_w;

  typedef struct {
    logic [7:0] ar, ai, br, bi;
    bit         cj;
    logic [7:0] er, ei;
    bit         eo;
  } vec_t;

  typedef struct {
    logic [7:0] rs, ims, rw, iw;
    bit         os, ow, fc;
  } res_t;

  vec_t    tbl[9];
  res_t    exp_q[$];
  longint  m_re, m_im;
  int      m_n;
  int      n_checks = 0;
  int      n_pass = 0;
  int      n_results = 0;
  int      n_forced = 0;

  mac_fixed_complex #(.QI(QI), .QF(QF), .MAX_LEN(MAX_LEN), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_conj(in_conj),
    .a_Re(a_re), .a_Im(a_im), .b_Re(b_re), .b_Im(b_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_Re(y_re), .y_Im(y_im), .overflow(overflow), .forced(forced)
  );

  mac_fixed_complex #(.QI(QI), .QF(QF), .MAX_LEN(MAX_LEN), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_last(in_last), .in_conj(in_conj),
    .a_Re(a_re), .a_Im(a_im), .b_Re(b_re), .b_Im(b_im),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .y_Re(y_re_w), .y_Im(y_im_w), .overflow(overflow_w), .forced(forced_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
  endtask

  // Real-valued frame result scaled by 2^-QF, floored, then clamped or wrapped to W bits.
  function automatic logic [8:0] model_reduce(input longint v, input bit sat);
    longint d, f, mx, mn;
    logic [7:0] y;
    bit o;
    d = 1 << QF;
    if (v >= 0) f = v / d;
    else f = -((-v + d - 1) / d);
    mx = (1 << (W - 1)) - 1;
    mn = -mx - 1;
    o = (f > mx) || (f < mn);
    if (sat && f > mx) y = 8'h7F;
    else if (sat && f < mn) y = 8'h80;
    else y = f[7:0];
    return {o, y};
  endfunction

  // One clock: observe at the falling edge (model + result check), return just after the rising edge.
  task automatic tick(output bit took);
    longint ar, ai, br, bi;
    logic [8:0] rs, ims, rw, iw;
    res_t e;
    @(negedge clk);
    took = in_valid && in_ready && !rst;
    if (rst) begin
      m_re = 0;
      m_im = 0;
      m_n = 0;
      exp_q.delete();
    end else begin
      if (took) begin
        ar = longint'($signed(a_re));
        ai = longint'($signed(a_im));
        br = longint'($signed(b_re));
        bi = longint'($signed(b_im));
        if (in_conj) begin
          m_re += ar * br + ai * bi;
          m_im += ai * br - ar * bi;
        end else begin
          m_re += ar * br - ai * bi;
          m_im += ai * br + ar * bi;
        end
        m_n++;
        if (in_last || m_n == MAX_LEN) begin
          rs = model_reduce(m_re, 1'b1);
          ims = model_reduce(m_im, 1'b1);
          rw = model_reduce(m_re, 1'b0);
          iw = model_reduce(m_im, 1'b0);
          e.rs = rs[7:0];
          e.ims = ims[7:0];
          e.os = rs[8] | ims[8];
          e.rw = rw[7:0];
          e.iw = iw[7:0];
          e.ow = rw[8] | iw[8];
          e.fc = !in_last;
          exp_q.push_back(e);
          m_re = 0;
          m_im = 0;
          m_n = 0;
        end
      end
      if (out_valid && out_ready) begin
        n_results++;
        if (forced) n_forced++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got y=0x%0h/0x%0h, expected no result", y_re, y_im);
        end else begin
          e = exp_q.pop_front();
          chk("y_re", y_re, e.rs);
          chk("y_im", y_im, e.ims);
          chk("overflow", overflow, e.os);
          chk("forced", forced, e.fc);
          chk("wrap_valid", out_valid_w, 1);
          chk("wrap_y_re", y_re_w, e.rw);
          chk("wrap_y_im", y_im_w, e.iw);
          chk("wrap_overflow", overflow_w, e.ow);
          chk("wrap_forced", forced_w, e.fc);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ar, ai, br, bi, input bit cj, input bit lst);
    bit took;
    int t;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_conj = cj; in_last = lst; in_valid = 1'b1;
    t = 0;
    do begin
      tick(took);
      t++;
    end while (!took && t < 100);
    if (!took) begin
      n_checks++;
      $display("FAIL send_timeout: got no transfer in %0d cycles, expected a transfer", t);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    bit took;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick(took);
      lat++;
    end
  endtask

  initial begin
    bit took;
    int lat, res0, frc0;
    logic [7:0] cap_re, cap_im;

    tbl[0] = '{8'h34, 8'h21, 8'h28, 8'h18, 1'b0, 8'h50, 8'h7F, 1'b1};
    tbl[1] = '{8'h10, 8'h10, 8'h10, 8'h10, 1'b1, 8'h20, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 8'h00, 8'h08, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 8'h00, 8'h7F, 1'b1};
    tbl[4] = '{8'h80, 8'h00, 8'h7F, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1};
    tbl[5] = '{8'h00, 8'h10, 8'h00, 8'h10, 1'b1, 8'h10, 8'h00, 1'b0};
    tbl[6] = '{8'h18, 8'h00, 8'h18, 8'h00, 1'b0, 8'h24, 8'h00, 1'b0};
    tbl[7] = '{8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[8] = '{8'hFF, 8'h00, 8'h01, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_conj = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    tick(took);
    tick(took);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", {y_re, y_im}, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_forced", forced, 0);
    rst = 1'b0;
    tick(took);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, tbl[i].cj, 1'b1);
      wait_out(lat);
      chk("tbl_latency", lat, 3);
      chk("tbl_y_re", y_re, tbl[i].er);
      chk("tbl_y_im", y_im, tbl[i].ei);
      chk("tbl_overflow", overflow, tbl[i].eo);
      if (i == 0) begin
        chk("wrap_scn1_y_im", y_im_w, 8'hA0);
        chk("wrap_scn1_ovf", overflow_w, 1);
      end
      tick(took);
    end

    res0 = n_results;
    for (int k = 0; k < 4; k++) send(8'h08, 8'h00, 8'h08, 8'h00, 1'b0, k == 3);
    wait_out(lat);
    chk("accum_latency", lat, 3);
    chk("accum_y_re", y_re, 8'h10);
    chk("accum_y_im", y_im, 8'h00);
    tick(took);
    chk("accum_one_result", n_results - res0, 1);

    out_ready = 1'b0;
    send(8'h20, 8'h00, 8'h10, 8'h00, 1'b0, 1'b1);
    wait_out(lat);
    cap_re = y_re;
    cap_im = y_im;
    chk("bp_first_y_re", cap_re, 8'h20);
    a_re = 8'h30; a_im = 8'h00; b_re = 8'h10; b_im = 8'h00;
    in_conj = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(took);
      chk("bp_took", took, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_y", {y_re, y_im}, {cap_re, cap_im});
    end
    out_ready = 1'b1;
    tick(took);
    chk("bp_release_took", took, 1);
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_second_latency", lat, 3);
    chk("bp_second_y_re", y_re, 8'h30);
    tick(took);

    res0 = n_results;
    frc0 = n_forced;
    for (int k = 0; k < 17; k++) send(8'h01, 8'h00, 8'h10, 8'h00, 1'b0, k == 16);
    repeat (6) tick(took);
    chk("force_results", n_results - res0, 2);
    chk("force_count", n_forced - frc0, 1);

    for (int k = 0; k < 3; k++) send(8'h10, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick(took);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y", {y_re, y_im}, 0);
    chk("midrst_flags", {overflow, forced}, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(took);
      chk("midrst_idle", out_valid, 0);
    end
    send(8'h20, 8'h00, 8'h18, 8'h00, 1'b0, 1'b1);
    wait_out(lat);
    chk("midrst_fresh_y_re", y_re, 8'h30);
    tick(took);

    for (int i = 0; i < 600; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        a_re = 8'($urandom);
        a_im = 8'($urandom);
        b_re = 8'($urandom);
        b_im = 8'($urandom);
        in_conj = 1'($urandom_range(0, 1));
        in_last = ($urandom_range(0, 5) == 0);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(took);
      if (took) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(8'h10, 8'h00, 8'h10, 8'h00, 1'b0, 1'b1);
    repeat (8) tick(took);
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
